// File: rtl/store_pkg.sv
// -----------------------------------------------------------------------------
// store_pkg
// Shared definitions for the store path (and reusable by the load path):
//   - size_e    : access size encoding carried on req_size
//   - state_e   : store_data_narrower FSM states
//   - is_misaligned / is_illegal : alignment checks on a byte offset
// -----------------------------------------------------------------------------
package store_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        ERR  = 3'd4
    } state_e;

    // True when an access of the given size cannot start at this byte offset.
    // Bytes are always aligned; the illegal size is reported by is_illegal.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_HALF: mis = offset[0];
            SZ_WORD: mis = (offset != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // A request that must be answered with err and no memory traffic.
    function automatic logic is_illegal(input logic [1:0] size,
                                        input logic [1:0] offset);
        return (size == SZ_ILLEGAL) || is_misaligned(size, offset);
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// -----------------------------------------------------------------------------
// store_lane_merge
// Combinational little-endian merge of store data into an existing word.
//   old_word    in  32  word currently held in memory
//   new_data    in  32  register value (low 8/16 bits for sub-word stores)
//   size        in  2   store size (store_pkg::size_e encoding)
//   offset      in  2   byte offset within the word (addr[1:0])
//   merged_word out 32  word to write back
// Lanes not covered by the store keep old_word. An illegal size leaves the
// word untouched; the FSM never writes in that case anyway.
// -----------------------------------------------------------------------------
module store_lane_merge
    import store_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    output logic [31:0] merged_word
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic       sel;
        logic [7:0] src;

        always_comb begin
            sel = 1'b0;
            src = new_data[8*gi +: 8];
            case (size)
                SZ_BYTE: begin
                    sel = (offset == 2'(gi));
                    src = new_data[7:0];
                end
                SZ_HALF: begin
                    // Lanes 0/1 form the low half, lanes 2/3 the high half;
                    // each pair takes bytes 0 and 1 of the register value.
                    sel = (offset[1] == 1'(gi / 2));
                    src = new_data[8*(gi % 2) +: 8];
                end
                SZ_WORD: begin
                    sel = 1'b1;
                    src = new_data[8*gi +: 8];
                end
                default: begin
                    sel = 1'b0;
                    src = new_data[8*gi +: 8];
                end
            endcase
        end

        assign merged_word[8*gi +: 8] = sel ? src : old_word[8*gi +: 8];
    end

endmodule

// File: rtl/store_data_narrower.sv
// -----------------------------------------------------------------------------
// store_data_narrower
// Narrows a 32-bit register value into a word-organised data memory that has
// no byte enables. Word stores are written directly; byte and halfword stores
// read the target word, merge the new lanes in and write it back.
//
//   clk        in   1         rising-edge clock
//   rst_n      in   1         synchronous active-low reset
//   req_valid  in   1         store request present (ignored unless idle)
//   req_ready  out  1         idle, a request is accepted this cycle
//   req_addr   in   ADDR_W    byte address
//   req_data   in   32        register value
//   req_size   in   2         00 byte, 01 half, 10 word, 11 illegal
//   done       out  1         one-cycle completion pulse
//   err        out  1         with done: misaligned/illegal, nothing written
//   mem_rd_en  out  1         one-cycle read strobe
//   mem_wr_en  out  1         one-cycle write strobe (same cycle as done)
//   mem_addr   out  ADDR_W-2  word address, non-zero only during RD and WR
//   mem_wdata  out  32        write data, valid with mem_wr_en
//   mem_rdata  in   32        read data, valid RD_LAT cycles after mem_rd_en
//
// RD_LAT must be at least 1.
// -----------------------------------------------------------------------------
module store_data_narrower
    import store_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              done,
    output logic              err,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    state_e              state_q;
    logic [ADDR_W-3:0]   word_addr_q;
    logic [1:0]          offset_q;
    logic [31:0]         data_q;
    logic [1:0]          size_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                done_q;
    logic                err_q;
    logic                rd_en_q;
    logic                wr_en_q;
    logic [ADDR_W-3:0]   mem_addr_q;
    logic [31:0]         wdata_q;

    logic [31:0]         merged_word;

    // Merge operates directly on the returning read data so the merged word
    // can be registered into mem_wdata on the same edge the read completes.
    store_lane_merge u_merge (
        .old_word    (mem_rdata),
        .new_data    (data_q),
        .size        (size_q),
        .offset      (offset_q),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_addr_q <= '0;
            offset_q    <= '0;
            data_q      <= '0;
            size_q      <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            mem_addr_q  <= '0;
            wdata_q     <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        word_addr_q <= req_addr[ADDR_W-1:2];
                        offset_q    <= req_addr[1:0];
                        data_q      <= req_data;
                        size_q      <= req_size;
                        if (is_illegal(req_size, req_addr[1:0])) begin
                            state_q <= ERR;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (req_size == SZ_WORD) begin
                            // Full word: no read needed, write on the next cycle.
                            state_q    <= WR;
                            wr_en_q    <= 1'b1;
                            done_q     <= 1'b1;
                            mem_addr_q <= req_addr[ADDR_W-1:2];
                            wdata_q    <= req_data;
                        end else begin
                            state_q    <= RD;
                            rd_en_q    <= 1'b1;
                            mem_addr_q <= req_addr[ADDR_W-1:2];
                        end
                    end
                end

                RD: begin
                    cnt_q      <= CNT_LOAD;
                    mem_addr_q <= '0;
                    state_q    <= WAIT;
                end

                WAIT: begin
                    if (cnt_q == '0) begin
                        wdata_q    <= merged_word;
                        wr_en_q    <= 1'b1;
                        done_q     <= 1'b1;
                        mem_addr_q <= word_addr_q;
                        state_q    <= WR;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                WR: begin
                    mem_addr_q <= '0;
                    wdata_q    <= '0;
                    state_q    <= IDLE;
                end

                ERR: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign mem_rd_en = rd_en_q;
    assign mem_wr_en = wr_en_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_store_data_narrower.sv
// -----------------------------------------------------------------------------
// tb_store_data_narrower
// Two instances: index 0 with RD_LAT = 1, index 1 with RD_LAT = 3, each with
// its own word memory model. Expected completions are queued when a request
// is accepted and checked when done pulses.
// -----------------------------------------------------------------------------
module tb_store_data_narrower;

    localparam int AW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    rst_n;
    logic [1:0]    req_valid;
    logic [AW-1:0] req_addr [2];
    logic [31:0]   req_data [2];
    logic [1:0]    req_size [2];

    wire  [1:0]    req_ready;
    wire  [1:0]    done;
    wire  [1:0]    err;
    wire  [1:0]    mem_rd_en;
    wire  [1:0]    mem_wr_en;
    wire  [AW-3:0] mem_addr [2];
    wire  [31:0]   mem_wdata [2];

    logic [31:0]   mem0 [16];
    logic [31:0]   mem1 [16];
    logic [31:0]   rpipe0;
    logic [31:0]   rpipe1 [3];
    logic          mem_init;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int rd_count [2] = '{0, 0};
    int wr_count [2] = '{0, 0};

    typedef struct {
        int          d;
        int          acc;
        int          lat;
        int          nrd;
        int          rd_base;
        logic        err;
        logic [31:0] wdata;
        logic [29:0] waddr;
    } exp_t;

    exp_t sb[$];

    store_data_narrower #(.ADDR_W(AW), .RD_LAT(1)) u_dut_lat1 (
        .clk       (clk),
        .rst_n     (rst_n[0]),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_addr  (req_addr[0]),
        .req_data  (req_data[0]),
        .req_size  (req_size[0]),
        .done      (done[0]),
        .err       (err[0]),
        .mem_rd_en (mem_rd_en[0]),
        .mem_wr_en (mem_wr_en[0]),
        .mem_addr  (mem_addr[0]),
        .mem_wdata (mem_wdata[0]),
        .mem_rdata (rpipe0)
    );

    store_data_narrower #(.ADDR_W(AW), .RD_LAT(3)) u_dut_lat3 (
        .clk       (clk),
        .rst_n     (rst_n[1]),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_addr  (req_addr[1]),
        .req_data  (req_data[1]),
        .req_size  (req_size[1]),
        .done      (done[1]),
        .err       (err[1]),
        .mem_rd_en (mem_rd_en[1]),
        .mem_wr_en (mem_wr_en[1]),
        .mem_addr  (mem_addr[1]),
        .mem_wdata (mem_wdata[1]),
        .mem_rdata (rpipe1[2])
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: read data is garbage except exactly RD_LAT cycles after
    // a read strobe, so a mistimed capture shows up as wrong write data.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem0[i] <= 32'hA5000000 | 32'(i);
        end else if (mem_wr_en[0]) begin
            mem0[mem_addr[0][3:0]] <= mem_wdata[0];
        end
        rpipe0 <= mem_rd_en[0] ? mem0[mem_addr[0][3:0]] : 32'hDEAD0BAD;
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem1[i] <= 32'h5A000000 | 32'(i);
        end else if (mem_wr_en[1]) begin
            mem1[mem_addr[1][3:0]] <= mem_wdata[1];
        end
        rpipe1[0] <= mem_rd_en[1] ? mem1[mem_addr[1][3:0]] : 32'hDEAD0BAD;
        rpipe1[1] <= rpipe1[0];
        rpipe1[2] <= rpipe1[1];
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] dat,
                                                input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] mask;
        logic [31:0] ins;
        case (sz)
            2'b00: begin
                mask = 32'hFF << (int'(off) * 8);
                ins  = (dat & 32'hFF) << (int'(off) * 8);
            end
            2'b01: begin
                mask = 32'hFFFF << (int'(off[1]) * 16);
                ins  = (dat & 32'hFFFF) << (int'(off[1]) * 16);
            end
            default: begin
                mask = 32'hFFFFFFFF;
                ins  = dat;
            end
        endcase
        return (old & ~mask) | ins;
    endfunction

    // Completion monitor
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rst_n[d] && !mem_init) begin
                if (mem_rd_en[d]) rd_count[d]++;
                if (mem_wr_en[d]) begin
                    wr_count[d]++;
                    check_eq("wr_with_done", 32'(done[d]), 32'd1);
                end
                if (err[d] && !done[d]) check_eq("err_without_done", 32'(err[d]), 32'd0);
                if (done[d]) begin
                    if (sb.size() == 0 || sb[0].d != d) begin
                        check_eq("spurious_done", 32'(done[d]), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("done_cycle", 32'(cyc), 32'(e.acc + e.lat));
                        check_eq("err", 32'(err[d]), 32'(e.err));
                        check_eq("wr_en", 32'(mem_wr_en[d]), 32'(!e.err));
                        check_eq("rd_strobes", 32'(rd_count[d] - e.rd_base), 32'(e.nrd));
                        if (!e.err) begin
                            check_eq("mem_wdata", mem_wdata[d], e.wdata);
                            check_eq("mem_addr", 32'(mem_addr[d]), 32'(e.waddr));
                        end
                        $display("txn dut%0d addr=0x%08h err=%0d wdata=0x%08h cycle=%0d",
                                 d, {e.waddr, 2'b00}, err[d], mem_wdata[d], cyc);
                    end
                end
            end
        end
    end

    task automatic send(input int d, input logic [31:0] a, input logic [31:0] dat,
                        input logic [1:0] sz, input bit push, input bit hold, output int acc);
        int   n;
        exp_t e;
        logic ex_err;
        logic [31:0] old;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_addr[d]  = a;
        req_data[d]  = dat;
        req_size[d]  = sz;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (!req_ready[d]) begin
            check_eq("accept_timeout", 32'(req_ready[d]), 32'd1);
            req_valid[d] = 1'b0;
            return;
        end
        ex_err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        old    = (d == 0) ? mem0[a[5:2]] : mem1[a[5:2]];
        if (push) begin
            e.d       = d;
            e.acc     = acc;
            e.err     = ex_err;
            e.lat     = (ex_err || sz == 2'b10) ? 1 : ((d == 0) ? 3 : 5);
            e.nrd     = (ex_err || sz == 2'b10) ? 0 : 1;
            e.rd_base = rd_count[d];
            e.wdata   = model_merge(old, dat, sz, a[1:0]);
            e.waddr   = a[31:2];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!hold) req_valid[d] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check_eq("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, acc1, acc2, acc;
        int wr_before;
        logic [31:0] ra, rd;
        logic [1:0]  rs;

        rst_n     = 2'b00;
        req_valid = 2'b00;
        mem_init  = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_addr[d] = '0;
            req_data[d] = '0;
            req_size[d] = '0;
        end
        repeat (3) @(negedge clk);

        // Reset state of both instances
        for (int d = 0; d < 2; d++) begin
            check_eq("rst_ready", 32'(req_ready[d]), 32'd1);
            check_eq("rst_done", 32'(done[d]), 32'd0);
            check_eq("rst_err", 32'(err[d]), 32'd0);
            check_eq("rst_rd_en", 32'(mem_rd_en[d]), 32'd0);
            check_eq("rst_wr_en", 32'(mem_wr_en[d]), 32'd0);
            check_eq("rst_mem_addr", 32'(mem_addr[d]), 32'd0);
            check_eq("rst_mem_wdata", mem_wdata[d], 32'd0);
        end
        rst_n    = 2'b11;
        mem_init = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", 32'(req_ready[0]), 32'd1);

        // Word store
        send(0, 32'h10, 32'hDEADBEEF, 2'b10, 1, 0, acc); drain();
        check_eq("word_mem", mem0[4], 32'hDEADBEEF);

        // Byte store into lane 3
        send(0, 32'h10, 32'h11223344, 2'b10, 1, 0, acc); drain();
        send(0, 32'h13, 32'h000000AB, 2'b00, 1, 0, acc); drain();
        check_eq("byte_mem", mem0[4], 32'hAB223344);

        // Half stores, upper then lower
        send(0, 32'h10, 32'h11223344, 2'b10, 1, 0, acc); drain();
        send(0, 32'h12, 32'hFFFFCAFE, 2'b01, 1, 0, acc); drain();
        check_eq("half_hi_mem", mem0[4], 32'hCAFE3344);
        send(0, 32'h10, 32'h11223344, 2'b10, 1, 0, acc); drain();
        send(0, 32'h10, 32'hFFFFCAFE, 2'b01, 1, 0, acc); drain();
        check_eq("half_lo_mem", mem0[4], 32'h1122CAFE);

        // Illegal requests leave memory untouched
        send(0, 32'h11, 32'h12345678, 2'b01, 1, 0, acc); drain();
        send(0, 32'h12, 32'h12345678, 2'b10, 1, 0, acc); drain();
        send(0, 32'h10, 32'h12345678, 2'b11, 1, 0, acc); drain();
        check_eq("err_mem", mem0[4], 32'h1122CAFE);

        // Back-to-back word stores with req_valid held
        send(0, 32'h0, 32'h0000AAAA, 2'b10, 1, 1, acc0);
        send(0, 32'h4, 32'h0000BBBB, 2'b10, 1, 1, acc1);
        send(0, 32'h8, 32'h0000CCCC, 2'b10, 1, 1, acc2);
        req_valid[0] = 1'b0;
        drain();
        check_eq("b2b_gap1", 32'(acc1 - acc0), 32'd2);
        check_eq("b2b_gap2", 32'(acc2 - acc1), 32'd2);
        check_eq("b2b_mem2", mem0[2], 32'h0000CCCC);

        // Random mix of sizes, offsets and illegal requests
        for (int i = 0; i < 24; i++) begin
            ra = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
            rd = $urandom;
            rs = 2'($urandom_range(0, 3));
            send(0, ra, rd, rs, 1, 0, acc);
        end
        drain();

        // RD_LAT = 3 instance: word, then byte with longer read latency
        send(1, 32'h14, 32'h11223344, 2'b10, 1, 0, acc); drain();
        send(1, 32'h15, 32'h000000EE, 2'b00, 1, 0, acc); drain();
        check_eq("lat3_byte_mem", mem1[5], 32'h1122EE44);

        // Reset during WAIT drops the request
        send(1, 32'h10, 32'h55667788, 2'b10, 1, 0, acc); drain();
        wr_before = wr_count[1];
        send(1, 32'h10, 32'h00000099, 2'b00, 0, 0, acc);
        @(negedge clk);          // RD
        @(negedge clk);          // WAIT
        rst_n[1] = 1'b0;
        @(negedge clk);
        rst_n[1] = 1'b1;
        check_eq("midrst_ready", 32'(req_ready[1]), 32'd1);
        repeat (8) @(negedge clk);
        check_eq("midrst_no_write", 32'(wr_count[1] - wr_before), 32'd0);
        check_eq("midrst_ready_late", 32'(req_ready[1]), 32'd1);
        check_eq("midrst_mem", mem1[4], 32'h55667788);

        // Instance still works after the mid-operation reset
        send(1, 32'h12, 32'h0000BEEF, 2'b01, 1, 0, acc); drain();
        check_eq("post_rst_half_mem", mem1[4], 32'hBEEF7788);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
